// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style 4-bit bus receiver.
package lcd_pkg;

   typedef enum logic [1:0] {
      M8    = 2'd0,
      M4_HI = 2'd1,
      M4_LO = 2'd2
   } mode_e;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;
   localparam logic [7:0] CMD_ENTRY = 8'h04;
   localparam logic [7:0] CMD_DISP  = 8'h08;
   localparam logic [7:0] CMD_SHIFT = 8'h10;
   localparam logic [7:0] CMD_FUNC  = 8'h20;
   localparam logic [7:0] CMD_CGRAM = 8'h40;
   localparam logic [7:0] CMD_DDRAM = 8'h80;

   localparam logic [6:0] LINE1_BASE = 7'h40;
   localparam logic [6:0] LINE_END   = 7'h27;
   localparam logic [6:0] LINE1_END  = 7'h67;
   localparam logic [7:0] CHAR_SPACE = 8'h20;

   localparam int LCD_RS_BIT = 4;

   // Address lies inside one of the two 40-column line windows.
   function automatic logic ddram_ok(input logic [6:0] a);
      return (a <= LINE_END) || ((a >= LINE1_BASE) && (a <= LINE1_END));
   endfunction

   // Next DDRAM address after a data write; lines wrap into each other.
   function automatic logic [6:0] ddram_step(input logic [6:0] a, input logic up);
      if (up) begin
         if (a == LINE_END)  return LINE1_BASE;
         if (a == LINE1_END) return 7'h00;
         return a + 7'd1;
      end
      if (a == 7'h00)      return LINE1_END;
      if (a == LINE1_BASE) return LINE_END;
      return a - 7'd1;
   endfunction

endpackage

// File: rtl/lcd_rx_deframer.sv
// Turns E/D strobes into bytes and tracks the 8-bit / 4-bit nibble phase.
module lcd_rx_deframer
   import lcd_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] lcd_d_i,
   input  logic       lcd_e_i,
   input  logic       busy_i,
   output logic       byte_valid_o,
   output logic       rs_o,
   output logic [7:0] byte_o,
   output logic       m8_o,
   output logic       frame_err_o,
   output logic       busy_err_o,
   output logic       mode4_o
);

   logic       e_q;
   logic [4:0] d_q;
   mode_e      state_q, state_d;
   logic [3:0] hi_q, hi_d;
   logic       hirs_q, hirs_d;
   logic       fall;
   logic       rs;
   logic [7:0] full_byte;

   assign fall      = e_q & ~lcd_e_i;
   assign rs        = d_q[LCD_RS_BIT];
   assign full_byte = {hi_q, d_q[3:0]};
   assign mode4_o   = (state_q != M8);

   // Strobe capture: hold the bus while E is high, remember E for edge detect.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         e_q <= 1'b0;
         d_q <= '0;
      end else begin
         e_q <= lcd_e_i;
         if (lcd_e_i) d_q <= lcd_d_i;
      end
   end

   // Mode state and pending high nibble.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= M8;
         hi_q    <= '0;
         hirs_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         hirs_q  <= hirs_d;
      end
   end

   // Phase FSM; strobes during a clear are rejected without moving the phase.
   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      hirs_d       = hirs_q;
      byte_valid_o = 1'b0;
      rs_o         = rs;
      byte_o       = {d_q[3:0], 4'h0};
      m8_o         = 1'b0;
      frame_err_o  = 1'b0;
      busy_err_o   = 1'b0;
      if (fall) begin
         if (busy_i) begin
            busy_err_o = 1'b1;
         end else begin
            case (state_q)
               M8: begin
                  byte_valid_o = 1'b1;
                  m8_o         = 1'b1;
                  if (!rs && d_q[3:0] == 4'b0010) state_d = M4_HI;
               end
               M4_HI: begin
                  hi_d    = d_q[3:0];
                  hirs_d  = rs;
                  state_d = M4_LO;
               end
               M4_LO: begin
                  state_d = M4_HI;
                  byte_o  = full_byte;
                  if (hirs_q != rs) begin
                     frame_err_o = 1'b1;
                  end else begin
                     byte_valid_o = 1'b1;
                     // function set with DL=1 drops back to 8-bit framing
                     if (!rs && full_byte[7:5] == 3'b001 && full_byte[4]) state_d = M8;
                  end
               end
               default: state_d = M8;
            endcase
         end
      end
   end

endmodule

// File: rtl/lcd_rx_monitor.sv
// LCD bus responder: decodes bytes, tracks controller state, keeps a 2x16 shadow.
module lcd_rx_monitor
   import lcd_pkg::*;
#(
   parameter int CLR_CYCLES = 32
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [4:0] LCD_D,
   input  logic       LCD_E,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       cmd_valid,
   output logic       cmd_rs,
   output logic [7:0] cmd_byte,
   output logic       char_wr,
   output logic [6:0] ddram_addr,
   output logic       mode4,
   output logic       two_line,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       incr,
   output logic       busy,
   output logic       proto_err
);

   localparam int CW = $clog2(CLR_CYCLES + 1);

   logic          byte_valid, rs, m8, frame_err, busy_err;
   logic [7:0]    rx_byte;
   logic [6:0]    addr_q, addr_d;
   logic          two_q, two_d, disp_q, disp_d, cur_q, cur_d, blink_q, blink_d, incr_q, incr_d;
   logic          cv_q, cv_d, crs_q, crs_d, cw_q, cw_d, perr_q, perr_d, busy_q;
   logic [7:0]    cbyte_q, cbyte_d, rd_q;
   logic [CW-1:0] clr_cnt_q;
   logic          clr_start;
   logic          wr_en;
   logic [4:0]    wr_idx;
   logic [7:0]    wr_dat;
   logic [7:0]    mem [32];

   lcd_rx_deframer u_deframer (
      .clk_i       (CLK),
      .rst_i       (RST),
      .lcd_d_i     (LCD_D),
      .lcd_e_i     (LCD_E),
      .busy_i      (busy_q),
      .byte_valid_o(byte_valid),
      .rs_o        (rs),
      .byte_o      (rx_byte),
      .m8_o        (m8),
      .frame_err_o (frame_err),
      .busy_err_o  (busy_err),
      .mode4_o     (mode4)
   );

   // Byte decode, address advance and buffer write selection.
   always_comb begin
      addr_d    = addr_q;
      two_d     = two_q;
      disp_d    = disp_q;
      cur_d     = cur_q;
      blink_d   = blink_q;
      incr_d    = incr_q;
      cv_d      = 1'b0;
      cw_d      = 1'b0;
      crs_d     = crs_q;
      cbyte_d   = cbyte_q;
      perr_d    = frame_err | busy_err;
      clr_start = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = {addr_q[6], addr_q[3:0]};
      wr_dat    = rx_byte;
      if (byte_valid) begin
         cv_d    = 1'b1;
         crs_d   = rs;
         cbyte_d = rx_byte;
         if (m8) begin
            // 8-bit phase only honours function set
            if (!rs && rx_byte[7:5] == 3'b001) two_d = rx_byte[3];
         end else if (!rs) begin
            if (|(rx_byte & CMD_DDRAM)) begin
               if (ddram_ok(rx_byte[6:0])) addr_d = rx_byte[6:0];
               else                        perr_d = 1'b1;
            end else if (|(rx_byte & CMD_CGRAM)) begin
            end else if (|(rx_byte & CMD_FUNC)) begin
               two_d = rx_byte[3];
            end else if (|(rx_byte & CMD_SHIFT)) begin
            end else if (|(rx_byte & CMD_DISP)) begin
               {disp_d, cur_d, blink_d} = rx_byte[2:0];
            end else if (|(rx_byte & CMD_ENTRY)) begin
               incr_d = rx_byte[1];
            end else if (|(rx_byte & CMD_HOME)) begin
               addr_d = '0;
            end else if (|(rx_byte & CMD_CLEAR)) begin
               addr_d    = '0;
               incr_d    = 1'b1;
               clr_start = 1'b1;
            end
         end else begin
            // columns 0..15 of either line are visible
            if (addr_q[5:4] == 2'b00) begin
               wr_en = 1'b1;
               cw_d  = 1'b1;
            end
            addr_d = ddram_step(addr_q, incr_q);
         end
      end
      // a clear owns the write port; data strobes are rejected while busy
      if (busy_q && clr_cnt_q < CW'(32)) begin
         wr_en  = 1'b1;
         wr_idx = clr_cnt_q[4:0];
         wr_dat = CHAR_SPACE;
      end
   end

   // Controller state, event pulses and the clear sequencer.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         addr_q    <= '0;
         two_q     <= 1'b0;
         disp_q    <= 1'b0;
         cur_q     <= 1'b0;
         blink_q   <= 1'b0;
         incr_q    <= 1'b1;
         cv_q      <= 1'b0;
         crs_q     <= 1'b0;
         cbyte_q   <= '0;
         cw_q      <= 1'b0;
         perr_q    <= 1'b0;
         busy_q    <= 1'b0;
         clr_cnt_q <= '0;
         rd_q      <= '0;
      end else begin
         addr_q  <= addr_d;
         two_q   <= two_d;
         disp_q  <= disp_d;
         cur_q   <= cur_d;
         blink_q <= blink_d;
         incr_q  <= incr_d;
         cv_q    <= cv_d;
         crs_q   <= crs_d;
         cbyte_q <= cbyte_d;
         cw_q    <= cw_d;
         perr_q  <= perr_d;
         if (clr_start) begin
            busy_q    <= 1'b1;
            clr_cnt_q <= '0;
         end else if (busy_q) begin
            if (clr_cnt_q == CW'(CLR_CYCLES - 1)) busy_q <= 1'b0;
            clr_cnt_q <= clr_cnt_q + CW'(1);
         end
         rd_q <= (wr_en && wr_idx == rd_addr) ? wr_dat : mem[rd_addr];
      end
   end

   // Shadow buffer storage; deliberately not reset.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_idx] <= wr_dat;
   end

   assign rd_data    = rd_q;
   assign cmd_valid  = cv_q;
   assign cmd_rs     = crs_q;
   assign cmd_byte   = cbyte_q;
   assign char_wr    = cw_q;
   assign ddram_addr = addr_q;
   assign two_line   = two_q;
   assign display_on = disp_q;
   assign cursor_on  = cur_q;
   assign blink_on   = blink_q;
   assign incr       = incr_q;
   assign busy       = busy_q;
   assign proto_err  = perr_q;

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Bench for lcd_rx_monitor: scenario tasks plus a byte-level reference model.
module tb_lcd_rx_monitor;

   logic       CLK = 1'b0;
   logic       RST;
   logic [4:0] LCD_D;
   logic       LCD_E;
   logic [4:0] rd_addr;
   logic [7:0] rd_data;
   logic       cmd_valid, cmd_rs, char_wr;
   logic [7:0] cmd_byte;
   logic [6:0] ddram_addr;
   logic       mode4, two_line, display_on, cursor_on, blink_on, incr, busy, proto_err;

   lcd_rx_monitor #(.CLR_CYCLES(32)) dut (
      .CLK(CLK), .RST(RST), .LCD_D(LCD_D), .LCD_E(LCD_E), .rd_addr(rd_addr), .rd_data(rd_data),
      .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_byte(cmd_byte), .char_wr(char_wr),
      .ddram_addr(ddram_addr), .mode4(mode4), .two_line(two_line), .display_on(display_on),
      .cursor_on(cursor_on), .blink_on(blink_on), .incr(incr), .busy(busy), .proto_err(proto_err)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   // posedge counter and event pulse counters (sampled just after the edge)
   int cyc = 0;
   int n_cmd = 0, n_chr = 0, n_perr = 0;
   always @(posedge CLK) begin
      cyc = cyc + 1;
      #1;
      if (cmd_valid === 1'b1) n_cmd = n_cmd + 1;
      if (char_wr   === 1'b1) n_chr = n_chr + 1;
      if (proto_err === 1'b1) n_perr = n_perr + 1;
   end

   // ---------------- reference model ----------------
   logic       m_mode4, m_have_hi, m_hirs;
   logic [3:0] m_hi;
   int         m_addr;
   logic       m_two, m_disp, m_cur, m_blink, m_incr;
   logic [7:0] m_buf [32];
   int         m_cmd = 0, m_chr = 0, m_perr = 0;
   int         m_clr_at = -1000;

   task automatic model_reset();
      m_mode4 = 0; m_have_hi = 0; m_hirs = 0; m_hi = 0;
      m_addr = 0; m_two = 0; m_disp = 0; m_cur = 0; m_blink = 0; m_incr = 1;
      m_clr_at = -1000;
   endtask

   // executes one complete byte in 4-bit mode, p = posedge index of execution
   task automatic model_exec(input logic rs, input logic [7:0] b, input int p);
      int line, col, a;
      m_cmd++;
      if (rs) begin
         line = (m_addr >= 64) ? 1 : 0;
         col  = m_addr - line * 64;
         if (col < 16) begin
            m_buf[line * 16 + col] = b;
            m_chr++;
         end
         if (m_incr) begin
            col++;
            if (col == 40) begin col = 0; line = 1 - line; end
         end else begin
            col--;
            if (col < 0) begin col = 39; line = 1 - line; end
         end
         m_addr = line * 64 + col;
      end else if (b >= 8'd128) begin
         a = int'(b) - 128;
         if (a < 40 || (a >= 64 && a < 104)) m_addr = a;
         else m_perr++;
      end else if (b >= 8'd64) begin
      end else if (b >= 8'd32) begin
         m_two = b[3];
         if (b[4]) begin m_mode4 = 0; m_have_hi = 0; end
      end else if (b >= 8'd16) begin
      end else if (b >= 8'd8) begin
         m_disp = b[2]; m_cur = b[1]; m_blink = b[0];
      end else if (b >= 8'd4) begin
         m_incr = b[1];
      end else if (b >= 8'd2) begin
         m_addr = 0;
      end else if (b == 8'd1) begin
         m_addr = 0; m_incr = 1;
         for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
         m_clr_at = p;
      end
   endtask

   task automatic model_strobe(input logic rs, input logic [3:0] nib, input int p);
      if (p > m_clr_at && p <= m_clr_at + 32) begin
         m_perr++;
      end else if (!m_mode4) begin
         m_cmd++;
         if (!rs && nib[3:1] == 3'b001) begin
            m_two = 0;
            if (!nib[0]) begin m_mode4 = 1; m_have_hi = 0; end
         end
      end else if (!m_have_hi) begin
         m_hi = nib; m_hirs = rs; m_have_hi = 1;
      end else begin
         m_have_hi = 0;
         if (m_hirs != rs) m_perr++;
         else model_exec(rs, {m_hi, nib}, p);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic strobe(input logic rs, input logic [3:0] nib);
      @(negedge CLK); LCD_D = {rs, nib}; LCD_E = 1'b1;
      @(negedge CLK); LCD_E = 1'b0;
      model_strobe(rs, nib, cyc + 1);
   endtask

   task automatic send_byte(input logic rs, input logic [7:0] b);
      strobe(rs, b[7:4]);
      strobe(rs, b[3:0]);
   endtask

   task automatic read_cell(input int i, output logic [7:0] v);
      @(negedge CLK); rd_addr = 5'(i);
      @(negedge CLK); v = rd_data;
   endtask

   // standard 4-bit init; returns the observed busy width after clear
   task automatic do_init(output int bcnt);
      strobe(0, 4'h3); idle(2); strobe(0, 4'h3); idle(2); strobe(0, 4'h3); idle(2);
      strobe(0, 4'h2); idle(2);
      send_byte(0, 8'h2C); send_byte(0, 8'h08); send_byte(0, 8'h01);
      bcnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge CLK);
         if (busy === 1'b1) bcnt++;
         else if (bcnt > 0) break;
      end
      send_byte(0, 8'h06); send_byte(0, 8'h0C); idle(2);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RST = 1'b1; LCD_E = 1'b0; LCD_D = '0; rd_addr = '0;
      model_reset();
      idle(3);
      vectors++; if (mode4 !== 1'b0) begin miscompares++; $display("FAIL reset mode4 got %b exp 0", mode4); end
      vectors++; if (ddram_addr !== 7'h00) begin miscompares++; $display("FAIL reset addr got %h exp 00", ddram_addr); end
      vectors++; if (incr !== 1'b1) begin miscompares++; $display("FAIL reset incr got %b exp 1", incr); end
      vectors++; if ({two_line, display_on, cursor_on, blink_on} !== 4'b0) begin miscompares++; $display("FAIL reset flags got %b exp 0000", {two_line, display_on, cursor_on, blink_on}); end
      vectors++; if ({busy, cmd_valid, char_wr, proto_err, cmd_rs} !== 5'b0) begin miscompares++; $display("FAIL reset pulses got %b exp 00000", {busy, cmd_valid, char_wr, proto_err, cmd_rs}); end
      vectors++; if (cmd_byte !== 8'h00) begin miscompares++; $display("FAIL reset cmd_byte got %h exp 00", cmd_byte); end
      vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset rd_data got %h exp 00", rd_data); end
      RST = 1'b0;
      idle(2);
   endtask

   task automatic test_init();
      int bc;
      int bad;
      logic [7:0] v;
      do_init(bc);
      vectors++; if (bc !== 32) begin miscompares++; $display("FAIL init busy_width got %0d exp 32", bc); end
      vectors++; if (mode4 !== 1'b1 || mode4 !== m_mode4) begin miscompares++; $display("FAIL init mode4 got %b exp 1", mode4); end
      vectors++; if (two_line !== 1'b1) begin miscompares++; $display("FAIL init two_line got %b exp 1", two_line); end
      vectors++; if ({display_on, cursor_on, blink_on} !== 3'b100) begin miscompares++; $display("FAIL init disp got %b exp 100", {display_on, cursor_on, blink_on}); end
      vectors++; if (ddram_addr !== 7'h00) begin miscompares++; $display("FAIL init addr got %h exp 00", ddram_addr); end
      vectors++; if (incr !== 1'b1) begin miscompares++; $display("FAIL init incr got %b exp 1", incr); end
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         read_cell(i, v);
         if (v !== 8'h20) bad++;
      end
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL init cleared_cells got %0d non-space exp 0", bad); end
   endtask

   task automatic test_text();
      int c0;
      logic [7:0] v;
      c0 = n_chr;
      send_byte(1, 8'h48); send_byte(1, 8'h49);
      send_byte(0, 8'hC0);
      send_byte(1, 8'h4F); send_byte(1, 8'h4B);
      idle(2);
      vectors++; if (cmd_byte !== 8'h4B || cmd_rs !== 1'b1) begin miscompares++; $display("FAIL text last_cmd got %b/%h exp 1/4b", cmd_rs, cmd_byte); end
      vectors++; if (ddram_addr !== 7'h42) begin miscompares++; $display("FAIL text addr got %h exp 42", ddram_addr); end
      vectors++; if (n_chr - c0 !== 4) begin miscompares++; $display("FAIL text char_wr got %0d exp 4", n_chr - c0); end
      read_cell(0, v);  vectors++; if (v !== 8'h48) begin miscompares++; $display("FAIL text cell0 got %h exp 48", v); end
      read_cell(1, v);  vectors++; if (v !== 8'h49) begin miscompares++; $display("FAIL text cell1 got %h exp 49", v); end
      read_cell(16, v); vectors++; if (v !== 8'h4F) begin miscompares++; $display("FAIL text cell16 got %h exp 4f", v); end
      read_cell(17, v); vectors++; if (v !== 8'h4B) begin miscompares++; $display("FAIL text cell17 got %h exp 4b", v); end
   endtask

   task automatic test_wrap();
      int c0;
      logic [7:0] v;
      c0 = n_chr;
      send_byte(0, 8'hA7); send_byte(1, 8'h41); idle(2);
      vectors++; if (n_chr - c0 !== 0) begin miscompares++; $display("FAIL wrap hidden_write got %0d exp 0", n_chr - c0); end
      vectors++; if (ddram_addr !== 7'h40) begin miscompares++; $display("FAIL wrap fwd_addr got %h exp 40", ddram_addr); end
      send_byte(0, 8'h04); send_byte(0, 8'h80); send_byte(1, 8'h42); idle(2);
      vectors++; if (ddram_addr !== 7'h67 || incr !== 1'b0) begin miscompares++; $display("FAIL wrap back_addr got %h/%b exp 67/0", ddram_addr, incr); end
      read_cell(0, v);
      vectors++; if (v !== m_buf[0]) begin miscompares++; $display("FAIL wrap cell0 got %h exp %h", v, m_buf[0]); end
   endtask

   task automatic test_busy_strobe();
      int p0;
      logic [7:0] v;
      send_byte(0, 8'h01);
      idle(5);
      p0 = n_perr;
      strobe(1, 4'h5);
      idle(2);
      vectors++; if (n_perr - p0 !== 1) begin miscompares++; $display("FAIL busy perr got %0d exp 1", n_perr - p0); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy still_busy got %b exp 1", busy); end
      idle(40);
      send_byte(1, 8'h5A); idle(2);
      vectors++; if (ddram_addr !== 7'h01) begin miscompares++; $display("FAIL busy after_addr got %h exp 01", ddram_addr); end
      read_cell(0, v); vectors++; if (v !== 8'h5A) begin miscompares++; $display("FAIL busy cell0 got %h exp 5a", v); end
      read_cell(1, v); vectors++; if (v !== 8'h20) begin miscompares++; $display("FAIL busy cell1 got %h exp 20", v); end
   endtask

   task automatic test_proto();
      int p0, c0, k0;
      logic [6:0] a0;
      logic [7:0] v;
      a0 = ddram_addr; p0 = n_perr;
      send_byte(0, 8'hB0); idle(2);
      vectors++; if (n_perr - p0 !== 1) begin miscompares++; $display("FAIL proto ddram_perr got %0d exp 1", n_perr - p0); end
      vectors++; if (ddram_addr !== a0) begin miscompares++; $display("FAIL proto ddram_addr got %h exp %h", ddram_addr, a0); end
      p0 = n_perr; c0 = n_chr; k0 = n_cmd;
      strobe(1, 4'h4); strobe(0, 4'h1); idle(2);
      vectors++; if (n_perr - p0 !== 1) begin miscompares++; $display("FAIL proto rs_perr got %0d exp 1", n_perr - p0); end
      vectors++; if (n_chr - c0 !== 0 || n_cmd - k0 !== 0) begin miscompares++; $display("FAIL proto rs_discard got %0d/%0d exp 0/0", n_chr - c0, n_cmd - k0); end
      send_byte(1, 8'h33); idle(2);
      read_cell(1, v);
      vectors++; if (v !== 8'h33) begin miscompares++; $display("FAIL proto realign got %h exp 33", v); end
   endtask

   task automatic test_random();
      int op, line, col, a;
      logic [7:0] b, v;
      int bad;
      for (int it = 0; it < 80; it++) begin
         op = $urandom_range(0, 5);
         case (op)
            0: begin
               if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 127);
               else begin line = $urandom_range(0, 1); col = $urandom_range(0, 39); a = line * 64 + col; end
               b = 8'h80 | 8'(a);
               send_byte(0, b);
            end
            1: begin b = 8'($urandom_range(32, 126)); send_byte(1, b); end
            2: begin b = 8'h04 | 8'($urandom_range(0, 3)); send_byte(0, b); end
            3: begin b = 8'h08 | 8'($urandom_range(0, 7)); send_byte(0, b); end
            4: send_byte(0, 8'h02);
            default: begin
               b = ($urandom_range(0, 1) == 1) ? (8'h40 | 8'($urandom_range(0, 63))) : (8'h10 | 8'($urandom_range(0, 15)));
               send_byte(0, b);
            end
         endcase
         idle(2);
         vectors++; if (ddram_addr !== 7'(m_addr) || incr !== m_incr) begin miscompares++; $display("FAIL rand[%0d] addr/incr got %h/%b exp %h/%b", it, ddram_addr, incr, 7'(m_addr), m_incr); end
         vectors++; if ({display_on, cursor_on, blink_on} !== {m_disp, m_cur, m_blink}) begin miscompares++; $display("FAIL rand[%0d] disp got %b exp %b", it, {display_on, cursor_on, blink_on}, {m_disp, m_cur, m_blink}); end
      end
      vectors++; if (n_chr !== m_chr || n_cmd !== m_cmd || n_perr !== m_perr) begin miscompares++; $display("FAIL rand counts got %0d/%0d/%0d exp %0d/%0d/%0d", n_chr, n_cmd, n_perr, m_chr, m_cmd, m_perr); end
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         read_cell(i, v);
         if (v !== m_buf[i]) begin bad++; $display("FAIL rand cell%0d got %h exp %h", i, v, m_buf[i]); end
      end
      vectors++; if (bad != 0) miscompares++;
   endtask

   task automatic test_rst_mid();
      int bc;
      strobe(0, 4'h2);
      idle(1);
      RST = 1'b1;
      model_reset();
      idle(2);
      RST = 1'b0;
      idle(1);
      vectors++; if (mode4 !== m_mode4 || mode4 !== 1'b0) begin miscompares++; $display("FAIL rst mode4 got %b exp 0", mode4); end
      vectors++; if ({two_line, display_on, cursor_on, blink_on, busy} !== 5'b0) begin miscompares++; $display("FAIL rst flags got %b exp 00000", {two_line, display_on, cursor_on, blink_on, busy}); end
      vectors++; if (ddram_addr !== 7'h00 || incr !== 1'b1) begin miscompares++; $display("FAIL rst addr/incr got %h/%b exp 00/1", ddram_addr, incr); end
      do_init(bc);
      vectors++; if (bc !== 32) begin miscompares++; $display("FAIL rst reinit_busy got %0d exp 32", bc); end
      vectors++; if ({mode4, two_line, display_on} !== 3'b111) begin miscompares++; $display("FAIL rst reinit got %b exp 111", {mode4, two_line, display_on}); end
      vectors++; if (n_chr !== m_chr || n_cmd !== m_cmd || n_perr !== m_perr) begin miscompares++; $display("FAIL rst counts got %0d/%0d/%0d exp %0d/%0d/%0d", n_chr, n_cmd, n_perr, m_chr, m_cmd, m_perr); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_text();
      test_wrap();
      test_busy_strobe();
      test_proto();
      test_random();
      test_rst_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lcd_rx_monitor.md
# lcd_rx_monitor

Receiving end of the 4-bit HD44780-style LCD bus driven by the team's LCD text/init sender. It deframes `LCD_E`/`LCD_D` strobes into instructions and data bytes and tracks controller state: interface mode, DDRAM address, entry mode and display flags. It also maintains a 2x16 character shadow buffer readable by the fabric. It is used on-chip for self-check and loopback, and in the bench as the bus responder model.

## Interface
Parameters:
- `CLR_CYCLES`, default 32: busy cycles for clear display (one buffer cell per cycle; minimum 32).

Ports:
- `CLK` in 1: system clock. The same clock drives the sender.
- `RST` in 1: asynchronous, active-high reset.
- `LCD_D` in 5: bus data. Bit 4 is RS (1 = data, 0 = instruction); bits 3:0 are the nibble.
- `LCD_E` in 1: enable strobe. Data is taken on the falling edge.
- `rd_addr` in 5: shadow read index `{line, col[3:0]}`.
- `rd_data` out 8: character at `rd_addr`, registered.
- `cmd_valid` out 1: one-cycle pulse when a full byte has been executed.
- `cmd_rs` out 1: RS of that byte.
- `cmd_byte` out 8: the executed byte.
- `char_wr` out 1: one-cycle pulse when a data byte lands in a visible cell.
- `ddram_addr` out 7: current DDRAM address.
- `mode4` out 1: 1 = 4-bit interface active.
- `two_line`, `display_on`, `cursor_on`, `blink_on`, `incr` out 1 each: latched controller flags.
- `busy` out 1: high while a clear is in progress.
- `proto_err` out 1: one-cycle pulse on a protocol violation.

## Operation
- Strobe capture:
  - `LCD_D` is registered every cycle in which `LCD_E`=1.
  - A falling edge (registered E=1, current E=0) delivers the registered nibble and RS.
- Mode FSM with states `M8`, `M4_HI`, `M4_LO`. Reset state is `M8`.
  - In `M8`, each strobe is a complete byte `{nibble,4'h0}`. Only function set is honoured. If DL=0 (nibble 4'b0010), go to `M4_HI` and set `mode4`=1. All other `M8` bytes set `cmd_valid` but have no effect.
  - In `M4_HI`, store the high nibble and RS, then go to `M4_LO`.
  - In `M4_LO`, form the byte `{hi,lo}` and go to `M4_HI`. If RS differs between the two halves, pulse `proto_err` and discard the byte.
- Instruction decode (RS=0), highest set bit wins:
  - 0x80 set DDRAM: a valid address (0x00–0x27, 0x40–0x67) is loaded. Any other address pulses `proto_err` and leaves the address unchanged.
  - 0x40 CGRAM: ignored.
  - 0x20 function set: latch N into `two_line`. DL=1 returns to `M8` and clears `mode4`.
  - 0x10 shift: ignored.
  - 0x08 display control: latch D, C and B into `display_on`, `cursor_on` and `blink_on`.
  - 0x04 entry mode: latch I/D into `incr`. S is ignored.
  - 0x02 home: address becomes 0.
  - 0x01 clear: address becomes 0, `incr` becomes 1, all 32 cells become 0x20, and `busy` is asserted.
- Data (RS=1):
  - If the column (address low bits) is 0–15, write the byte to cell `{addr[6], addr[3:0]}` and pulse `char_wr`.
  - Then advance the address by ±1 according to `incr`.
  - Wrap rules: 0x27→0x40, 0x67→0x00, 0x00→0x67, 0x40→0x27.
- Busy: any falling edge while `busy`=1 pulses `proto_err` and is dropped. The nibble phase does not advance.

## Timing
- Reset values: FSM `M8`; `ddram_addr`=0; `incr`=1; `mode4`, `two_line`, `display_on`, `cursor_on`, `blink_on`, `busy`, `cmd_valid`, `char_wr`, `proto_err`, `cmd_rs`, `cmd_byte` all 0; `rd_data`=0.
- Shadow buffer contents are not reset; they are undefined until the first clear.
- Falling edge detected in cycle N (`LCD_E` sampled 0):
  - In cycle N+1: `cmd_valid`, `char_wr` and `proto_err` pulse; flags, address and buffer are updated.
  - In cycle N+2: `rd_data` reflects a write made to `rd_addr`.
- Clear: `busy` rises at N+1 and stays high for exactly `CLR_CYCLES` cycles, writing one cell per cycle. It falls at N+1+`CLR_CYCLES`.
- Read port: `rd_data` is valid one cycle after `rd_addr`. A simultaneous write to the same cell returns the new value.
- The minimum E-high width is 1 cycle; back-to-back strobes one cycle apart are legal.
- `RST` during a clear aborts it immediately. Cells left unwritten keep their stale contents.

## Structure
- Package `lcd_pkg`:
  - mode enum `{M8, M4_HI, M4_LO}`
  - instruction bit masks (`CMD_CLEAR`, `CMD_HOME`, `CMD_ENTRY`, `CMD_DISP`, `CMD_SHIFT`, `CMD_FUNC`, `CMD_CGRAM`, `CMD_DDRAM`)
  - `LINE1_BASE`=7'h40, `LINE_END`=7'h27, `CHAR_SPACE`=8'h20
  - `LCD_RS_BIT`=4
- Sub-module `lcd_rx_deframer`: E edge detect, nibble latch and the mode FSM. It outputs `byte_valid`/`rs`/`byte`. The top level holds the decoder, DDRAM address, flags, clear sequencer and 32x8 buffer.

## Test plan
- Standard init, 4-bit: 3,3,3,2 then 2C,08,01,06,0C.
  - Expect `mode4`=1, `two_line`=1, and `display_on`=1 with cursor and blink 0.
  - Expect `busy` high for 32 cycles after 0x01, then all cells 0x20 and `ddram_addr`=0.
- Text "HI", then 0xC0, then "OK".
  - Expect cells 0,1 = 0x48,0x49 and cells 16,17 = 0x4F,0x4B.
  - Expect `ddram_addr`=0x42 and four `char_wr` pulses.
- Address wrap: set 0xA7 (address 0x27), write 0x41.
  - Expect no `char_wr` and `ddram_addr`=0x40.
  - Then entry 0x04 (decrement) and a write at 0x00: expect `ddram_addr`=0x67.
- Strobe during a clear: issue 0x01, then send a data nibble 5 cycles later.
  - Expect a `proto_err` pulse, the nibble dropped, and the next byte still decoded correctly.
- Protocol errors:
  - Set DDRAM 0xB0 (address 0x30): expect `proto_err` and the address unchanged.
  - High nibble with RS=1, low nibble with RS=0: expect `proto_err` and no write.
- Assert `RST` mid-byte (after a high nibble).
  - Expect FSM `M8`, `mode4`=0 and all flags at their reset values.
  - A subsequent full init must succeed.
